// File: rtl/udp_port_router.sv
// UDP destination-port router: steers one header+payload packet to the lowest
// enabled channel whose configured port matches, or drops and counts it.
module udp_port_router #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned HDR_W      = 128,
    parameter int unsigned DROP_CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH*16-1:0]    cfg_port,
    input  logic [NUM_CH-1:0]       cfg_en,
    input  logic                    in_hdr_valid,
    output logic                    in_hdr_ready,
    input  logic [15:0]             in_dest_port,
    input  logic [HDR_W-1:0]        in_hdr_fields,
    input  logic [7:0]              in_tdata,
    input  logic                    in_tvalid,
    output logic                    in_tready,
    input  logic                    in_tlast,
    input  logic                    in_tuser,
    output logic [NUM_CH-1:0]       out_hdr_valid,
    input  logic [NUM_CH-1:0]       out_hdr_ready,
    output logic [15:0]             out_dest_port,
    output logic [HDR_W-1:0]        out_hdr_fields,
    output logic [7:0]              out_tdata,
    output logic                    out_tlast,
    output logic                    out_tuser,
    output logic [NUM_CH-1:0]       out_tvalid,
    input  logic [NUM_CH-1:0]       out_tready,
    output logic [DROP_CNT_W-1:0]   drop_count,
    output logic                    busy
);

    localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, HDR, PAY, DROP} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [SEL_W-1:0]        r_sel;
    logic [15:0]             r_dest_port;
    logic [HDR_W-1:0]        r_hdr_fields;
    logic [DROP_CNT_W-1:0]   r_drop_count;

    logic                    w_match;
    logic [SEL_W-1:0]        w_match_idx;
    logic [NUM_CH-1:0]       w_sel_onehot;
    logic                    w_sel_tready;
    logic                    w_sel_hdr_ready;

    // Scan from the top down so the lowest matching index is the last one written.
    always_comb begin
        w_match     = 1'b0;
        w_match_idx = '0;
        for (int unsigned i = NUM_CH; i > 0; i--) begin
            if (cfg_en[i-1] && (cfg_port[(i-1)*16 +: 16] == in_dest_port)) begin
                w_match     = 1'b1;
                w_match_idx = SEL_W'(i - 1);
            end
        end
    end

    always_comb begin
        w_sel_onehot    = '0;
        w_sel_tready    = 1'b0;
        w_sel_hdr_ready = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (r_sel == SEL_W'(i)) begin
                w_sel_onehot[i] = 1'b1;
                w_sel_tready    = out_tready[i];
                w_sel_hdr_ready = out_hdr_ready[i];
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        in_hdr_ready  = 1'b0;
        in_tready     = 1'b0;
        out_hdr_valid = '0;
        out_tvalid    = '0;
        case (r_state)
            IDLE: begin
                in_hdr_ready = 1'b1;
                if (in_hdr_valid) w_next = w_match ? HDR : DROP;
            end
            HDR: begin
                out_hdr_valid = w_sel_onehot;
                if (w_sel_hdr_ready) w_next = PAY;
            end
            PAY: begin
                in_tready  = w_sel_tready;
                out_tvalid = in_tvalid ? w_sel_onehot : '0;
                if (in_tvalid && w_sel_tready && in_tlast) w_next = IDLE;
            end
            DROP: begin
                in_tready = 1'b1;
                if (in_tvalid && in_tlast) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_sel        <= '0;
            r_dest_port  <= '0;
            r_hdr_fields <= '0;
            r_drop_count <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && in_hdr_valid) begin
                r_sel        <= w_match_idx;
                r_dest_port  <= in_dest_port;
                r_hdr_fields <= in_hdr_fields;
            end
            if (r_state == DROP && in_tvalid && in_tlast && r_drop_count != '1)
                r_drop_count <= r_drop_count + DROP_CNT_W'(1);
        end
    end

    assign out_dest_port  = r_dest_port;
    assign out_hdr_fields = r_hdr_fields;
    assign out_tdata      = in_tdata;
    assign out_tlast      = in_tlast;
    assign out_tuser      = in_tuser;
    assign drop_count     = r_drop_count;
    assign busy           = (r_state != IDLE);

endmodule

// File: tb/tb_udp_port_router.sv
// Scoreboard bench for udp_port_router: a driver pushes expected headers/beats,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_udp_port_router;

    localparam int NCH = 4;
    localparam int HW  = 128;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NCH*16-1:0] cfg_port;
    logic [NCH-1:0]   cfg_en;
    logic             in_hdr_valid, in_hdr_ready;
    logic [15:0]      in_dest_port;
    logic [HW-1:0]    in_hdr_fields;
    logic [7:0]       in_tdata;
    logic             in_tvalid, in_tready, in_tlast, in_tuser;
    logic [NCH-1:0]   out_hdr_valid, out_hdr_ready;
    logic [15:0]      out_dest_port;
    logic [HW-1:0]    out_hdr_fields;
    logic [7:0]       out_tdata;
    logic             out_tlast, out_tuser;
    logic [NCH-1:0]   out_tvalid, out_tready;
    logic [1:0]       drop_count;
    logic             busy;

    udp_port_router #(.NUM_CH(NCH), .HDR_W(HW), .DROP_CNT_W(2)) dut (
        .clk(clk), .reset(reset), .cfg_port(cfg_port), .cfg_en(cfg_en),
        .in_hdr_valid(in_hdr_valid), .in_hdr_ready(in_hdr_ready),
        .in_dest_port(in_dest_port), .in_hdr_fields(in_hdr_fields),
        .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready),
        .in_tlast(in_tlast), .in_tuser(in_tuser),
        .out_hdr_valid(out_hdr_valid), .out_hdr_ready(out_hdr_ready),
        .out_dest_port(out_dest_port), .out_hdr_fields(out_hdr_fields),
        .out_tdata(out_tdata), .out_tlast(out_tlast), .out_tuser(out_tuser),
        .out_tvalid(out_tvalid), .out_tready(out_tready),
        .drop_count(drop_count), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int ch; logic [15:0] dest; logic [HW-1:0] f; } hdr_t;
    typedef struct { logic [7:0] d; logic l; logic u; } beat_t;

    hdr_t  hdr_q[$];
    beat_t beat_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    model_drops = 0;
    int    mode = 0;
    bit    mon_en = 0;
    bit    pay_active = 0;
    int    pay_ch = 0;
    int    hold = 0;
    bit    tgl = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference routing: lowest enabled channel with an equal port, -1 when none.
    function automatic int route(input logic [15:0] dest);
        for (int i = 0; i < NCH; i++)
            if (cfg_en[i] && cfg_port[i*16 +: 16] == dest) return i;
        return -1;
    endfunction

    function automatic logic [NCH-1:0] oh(input int ch);
        return (ch < 0) ? '0 : NCH'(1 << ch);
    endfunction

    // Sink readiness: 0 always ready, 1 random, 2 header stall of 4 cycles then toggling tready.
    always @(posedge clk) begin
        #1;
        case (mode)
            1: begin
                out_hdr_ready = NCH'($urandom);
                out_tready    = NCH'($urandom);
            end
            2: begin
                if (out_hdr_valid != 0 && hold < 4) begin
                    out_hdr_ready = '0;
                    hold++;
                end else begin
                    out_hdr_ready = '1;
                    if (out_hdr_valid == 0) hold = 0;
                end
                out_tready = tgl ? '1 : '0;
                tgl = ~tgl;
            end
            default: begin
                out_hdr_ready = '1;
                out_tready    = '1;
            end
        endcase
    end

    always @(negedge clk) begin
        if (reset) begin
            hdr_q.delete();
            beat_q.delete();
            pay_active = 0;
        end else if (mon_en) begin
            if (pay_active) begin
                chk("pay_tvalid", 128'(out_tvalid), 128'(in_tvalid ? oh(pay_ch) : '0));
                chk("tready_mirror", 128'(in_tready), 128'(out_tready[pay_ch]));
                if (in_tvalid && in_tready) begin
                    if (beat_q.size() == 0) begin
                        chk("beat_extra", 128'(beat_q.size()), 128'(1));
                    end else begin
                        beat_t b;
                        b = beat_q.pop_front();
                        chk("beat_data", 128'(out_tdata), 128'(b.d));
                        chk("beat_last", 128'(out_tlast), 128'(b.l));
                        chk("beat_user", 128'(out_tuser), 128'(b.u));
                        if (b.l) pay_active = 0;
                    end
                end
            end else begin
                chk("no_pay_tvalid", 128'(out_tvalid), 128'(0));
            end
            if (out_hdr_valid != 0) begin
                if (hdr_q.size() == 0) begin
                    chk("hdr_unexpected", 128'(out_hdr_valid), 128'(0));
                end else begin
                    hdr_t h;
                    h = hdr_q[0];
                    chk("hdr_valid", 128'(out_hdr_valid), 128'(oh(h.ch)));
                    chk("hdr_dest", 128'(out_dest_port), 128'(h.dest));
                    chk("hdr_fields", out_hdr_fields, h.f);
                    if ((out_hdr_valid & out_hdr_ready) != 0) begin
                        void'(hdr_q.pop_front());
                        pay_active = 1;
                        pay_ch = h.ch;
                    end
                end
            end
        end
    end

    task automatic send_pkt(input logic [15:0] dest, input int len, input bit gaps,
                            input bit scramble, input int rst_beat);
        int ch;
        bit ok;
        hdr_t h;
        beat_t bt;
        logic [HW-1:0] f;
        f = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        in_hdr_valid = 1; in_dest_port = dest; in_hdr_fields = f;
        ok = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_hdr_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            chk("hdr_ready_timeout", 128'(in_hdr_ready), 128'(1));
            in_hdr_valid = 0;
            return;
        end
        ch = route(dest);
        if (ch >= 0) begin
            h.ch = ch; h.dest = dest; h.f = f;
            hdr_q.push_back(h);
        end
        @(posedge clk); #1;
        in_hdr_valid = 0; in_dest_port = 16'($urandom); in_hdr_fields = '0;
        if (scramble) begin
            cfg_port = {$urandom, $urandom};
            cfg_en   = NCH'($urandom);
        end
        @(negedge clk);
        chk("hdr_latency", 128'(out_hdr_valid), 128'(oh(ch)));
        chk("busy_in_pkt", 128'(busy), 128'(1));
        for (int b = 0; b < len; b++) begin
            @(posedge clk); #1;
            if (gaps) repeat ($urandom_range(0, 2)) begin
                in_tvalid = 0; in_tdata = 8'($urandom); in_tlast = 1'($urandom);
                @(posedge clk); #1;
            end
            bt.d = 8'($urandom); bt.l = (b == len - 1); bt.u = 1'($urandom);
            in_tvalid = 1; in_tdata = bt.d; in_tlast = bt.l; in_tuser = bt.u;
            if (b == rst_beat) begin
                reset = 1;
                @(posedge clk); #1;
                chk("rst_hdr_valid", 128'(out_hdr_valid), 128'(0));
                chk("rst_tvalid", 128'(out_tvalid), 128'(0));
                chk("rst_busy", 128'(busy), 128'(0));
                chk("rst_drop", 128'(drop_count), 128'(0));
                in_tvalid = 0; in_tlast = 0;
                @(posedge clk); #1;
                reset = 0;
                model_drops = 0;
                @(negedge clk);
                chk("rst_hdr_ready", 128'(in_hdr_ready), 128'(1));
                chk("rst_drop_after", 128'(drop_count), 128'(0));
                return;
            end
            if (ch >= 0) beat_q.push_back(bt);
            ok = 0;
            for (int t = 0; t < 200; t++) begin
                @(negedge clk);
                if (ch < 0) chk("drop_tready", 128'(in_tready), 128'(1));
                if (in_tready) begin ok = 1; break; end
            end
            if (!ok) begin
                chk("beat_timeout", 128'(in_tready), 128'(1));
                in_tvalid = 0;
                return;
            end
        end
        @(posedge clk); #1;
        in_tvalid = 0; in_tlast = 0;
        if (ch < 0 && model_drops < 3) model_drops++;
        @(negedge clk);
        chk("busy_after_last", 128'(busy), 128'(0));
        chk("hdr_ready_after_last", 128'(in_hdr_ready), 128'(1));
        chk("drop_count", 128'(drop_count), 128'(model_drops));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cfg_port = '0; cfg_en = '0;
        in_hdr_valid = 0; in_dest_port = '0; in_hdr_fields = '0;
        in_tdata = '0; in_tvalid = 0; in_tlast = 0; in_tuser = 0;
        out_hdr_ready = '1; out_tready = '1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hdr_valid", 128'(out_hdr_valid), 128'(0));
        chk("reset_tvalid", 128'(out_tvalid), 128'(0));
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_drop", 128'(drop_count), 128'(0));
        chk("reset_dest", 128'(out_dest_port), 128'(0));
        chk("reset_fields", out_hdr_fields, 128'(0));
        reset = 0;
        mon_en = 1;
        chk("first_hdr_ready", 128'(in_hdr_ready), 128'(1));

        // Channels listed 0..3 as 1234, 80, 53, 7.
        cfg_port = {16'd7, 16'd53, 16'd80, 16'd1234};
        cfg_en = 4'b1111;
        send_pkt(16'd80, 5, 0, 0, -1);
        send_pkt(16'd9999, 3, 0, 0, -1);

        cfg_port = {16'd7, 16'd1234, 16'd80, 16'd1234};
        cfg_en = 4'b0101;
        send_pkt(16'd1234, 2, 0, 0, -1);
        cfg_en = 4'b0100;
        send_pkt(16'd1234, 1, 0, 0, -1);

        cfg_port = {16'd7, 16'd53, 16'd80, 16'd1234};
        cfg_en = 4'b1111;
        mode = 2;
        send_pkt(16'd80, 6, 0, 0, -1);
        mode = 0;
        send_pkt(16'd80, 4, 0, 0, 1);

        for (int i = 0; i < 5; i++)
            send_pkt(16'd9999, $urandom_range(1, 3), 1, 0, -1);

        mode = 1;
        for (int p = 0; p < 40; p++) begin
            for (int i = 0; i < NCH; i++) cfg_port[i*16 +: 16] = 16'(100 + $urandom_range(0, 3));
            cfg_en = NCH'($urandom);
            send_pkt(16'(100 + $urandom_range(0, 4)), $urandom_range(1, 6),
                     1'($urandom), 1'($urandom), -1);
        end
        mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("hdr_q_drained", 128'(hdr_q.size()), 128'(0));
        chk("beat_q_drained", 128'(beat_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/udp_port_router.md
UDP_PORT_ROUTER -- requirements
Module: udp_port_router

Interface
REQ-001 Parameter NUM_CH, default 4, number of output channels (1..16).
REQ-002 Parameter HDR_W, default 128, width of opaque UDP header field bundle forwarded unchanged.
REQ-003 Parameter DROP_CNT_W, default 16, width of the dropped-packet counter.
REQ-004 clk  in  1  clock; all logic is on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cfg_port  in  NUM_CH*16  per-channel match port; channel i uses bits [16i+15:16i].
REQ-007 cfg_en  in  NUM_CH  per-channel enable; a disabled channel never matches.
REQ-008 in_hdr_valid / in_hdr_ready  in / out  1 / 1  input header handshake.
REQ-009 in_dest_port  in  16  UDP destination port of the input header.
REQ-010 in_hdr_fields  in  HDR_W  remaining header fields.
REQ-011 in_tdata / in_tvalid / in_tready / in_tlast / in_tuser  in / in / out / in / in  8 / 1 / 1 / 1 / 1  input payload AXI-Stream.
REQ-012 out_hdr_valid / out_hdr_ready  out / in  NUM_CH / NUM_CH  per-channel header handshake.
REQ-013 out_dest_port / out_hdr_fields  out / out  16 / HDR_W  registered header, shared by all channels.
REQ-014 out_tdata / out_tlast / out_tuser  out  8 / 1 / 1  payload, shared by all channels.
REQ-015 out_tvalid / out_tready  out / in  NUM_CH / NUM_CH  per-channel payload handshake.
REQ-016 drop_count  out  DROP_CNT_W  number of packets dropped since reset; saturates.
REQ-017 busy  out  1  high whenever state is not IDLE.

Function
REQ-018 The FSM SHALL have four states: IDLE, HDR, PAY and DROP.
REQ-019 In IDLE, in_hdr_ready SHALL be 1; in every other state it SHALL be 0.
REQ-020 On an IDLE header handshake, the block SHALL register in_dest_port and in_hdr_fields.
REQ-021 On the same handshake, sel SHALL be set to the lowest index i with cfg_en[i] set and cfg_port[i] equal to in_dest_port.
REQ-022 On that handshake, the FSM SHALL go to HDR if any channel matched, else to DROP.
REQ-023 cfg_port and cfg_en SHALL be sampled only at the header handshake; changes mid-packet SHALL NOT affect the packet in flight.
REQ-024 In HDR, out_hdr_valid[sel] SHALL be 1 and all other bits 0; header latency from input handshake to out_hdr_valid is 1 cycle.
REQ-025 In HDR, on out_hdr_ready[sel], the FSM SHALL go to PAY; out_hdr_valid SHALL stay asserted with stable data until then.
REQ-026 In PAY, out_tvalid[sel] SHALL equal in_tvalid and in_tready SHALL equal out_tready[sel].
REQ-027 In PAY, the data path SHALL be combinational (zero latency): out_tdata, out_tlast and out_tuser follow the inputs.
REQ-028 In PAY, a handshake with in_tlast=1 SHALL return the FSM to IDLE on the next cycle.
REQ-029 In DROP, in_tready SHALL be 1 and all out_tvalid bits SHALL be 0.
REQ-030 In DROP, a handshake with in_tlast=1 SHALL increment drop_count by 1, saturating at all-ones, and return the FSM to IDLE.
REQ-031 In IDLE and HDR, in_tready SHALL be 0 and out_tvalid SHALL be 0, so payload is never consumed before its header is delivered.
REQ-032 A new header SHALL be accepted no earlier than the cycle after the previous tlast handshake, which gives a 1-cycle bubble.
REQ-033 A single-beat packet (tlast on the first beat) SHALL be handled identically to a multi-beat packet.
REQ-034 in_tuser SHALL be forwarded unmodified; the router SHALL NOT drop on tuser.
REQ-035 At most one bit of out_hdr_valid and at most one bit of out_tvalid SHALL be high in any cycle.

Reset
REQ-036 While reset is high, the FSM SHALL be IDLE, and out_hdr_valid, out_tvalid, busy, drop_count, sel and the header registers SHALL be 0.
REQ-037 Reset asserted in any state SHALL abandon the packet in flight without counting it.
REQ-038 After reset deasserts, in_hdr_ready SHALL be 1 on the first cycle.

Verification
REQ-039 cfg_port={1234,80,53,7}, cfg_en=4'b1111, header dest 80 followed by 5 payload bytes -> out_hdr_valid=4'b0010 one cycle after the handshake; 5 beats appear on channel 1 with tlast on the 5th; drop_count=0.
REQ-040 Header dest 9999 with 3 bytes -> no out_hdr_valid; in_tready=1 throughout; drop_count goes 0->1; busy is low the cycle after tlast.
REQ-041 cfg_port[0]=cfg_port[2]=1234, cfg_en=4'b0101, dest 1234 -> routed to channel 0 only; with cfg_en=4'b0100 -> routed to channel 2.
REQ-042 Backpressure on channel 1: out_hdr_ready held low 4 cycles, then out_tready toggling 1/0 -> header and data stay stable; no beat is lost or duplicated; in_tready mirrors out_tready[1].
REQ-043 Reset pulsed on the 2nd beat of PAY -> all valids are 0 the next cycle; in_hdr_ready=1 after release; drop_count=0.
REQ-044 DROP_CNT_W=2 with 5 unmatched packets -> drop_count reads 1, 2, 3, 3, 3.
